// File: rtl/sram_controller.sv
// -----------------------------------------------------------------------------
// sram_controller
//   Bridges a 32-bit memory-stage request onto a 16-bit asynchronous SRAM.
//   Each 32-bit access is split into two half-word phases (LOW, then HIGH),
//   and each phase holds its address/data on the pins for PHASE_CYCLES clocks.
//   The requester is stalled through 'ready' for the whole access, and then
//   sees a single ready-high DONE cycle.
//
// Parameters
//   PHASE_CYCLES  clocks per half-word phase (1..7)
//   ADDR_BASE     byte address that maps to SRAM word 0
//
// Ports
//   clk, rst              clock; asynchronous active-low reset
//   wr_en, rd_en          32-bit write / read request (both high = write)
//   address               byte address; bits [1:0] are ignored
//   write_data            write payload
//   read_data             last completed read word, held between reads
//   ready                 high when no access is in progress
//   SRAM_DQ               bidirectional SRAM data bus
//   SRAM_ADDR             SRAM half-word address {word index, half select}
//   SRAM_UB_N/LB_N/CE_N/OE_N  SRAM strobes; held active outside reset
//   SRAM_WE_N             SRAM write enable, active-low
// -----------------------------------------------------------------------------
module sram_controller #(
    parameter int          PHASE_CYCLES = 2,
    parameter logic [31:0] ADDR_BASE    = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    // Counter value of the final cycle of a phase.
    localparam logic [2:0] LAST = 3'(PHASE_CYCLES - 1);

    state_t      state;
    logic [2:0]  cnt;
    logic        op_wr;
    logic [16:0] idx;
    logic [31:0] wdata;
    logic        we_n_q;
    logic        dq_oe;
    logic [15:0] dq_out;

    // Word index: byte offset from the base, divided by four, wrapped to the
    // 17-bit SRAM word space. Addresses below the base wrap to the top.
    logic [31:0] offset;
    logic [16:0] req_idx;
    logic        unused_offset_bits;

    assign offset             = address - ADDR_BASE;
    assign req_idx            = offset[18:2];
    assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

    // A request cycle is stalled combinationally so the memory stage holds
    // its request until the access completes.
    always_comb begin
        ready = 1'b0;
        case (state)
            IDLE:    ready = ~(rd_en | wr_en);
            DONE:    ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // All pin-level outputs are registered and computed one cycle ahead, so
    // the values for the first phase cycle are loaded on the accepting edge.
    // WE_N is raised on the final cycle of each phase so the SRAM latches the
    // data before the address moves.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            op_wr     <= 1'b0;
            idx       <= 17'd0;
            wdata     <= 32'd0;
            read_data <= 32'd0;
            SRAM_ADDR <= 18'd0;
            we_n_q    <= 1'b1;
            dq_oe     <= 1'b0;
            dq_out    <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_en | wr_en) begin
                        state     <= LOW;
                        cnt       <= 3'd0;
                        op_wr     <= wr_en;
                        idx       <= req_idx;
                        wdata     <= write_data;
                        SRAM_ADDR <= {req_idx, 1'b0};
                        we_n_q    <= ~wr_en | (LAST == 3'd0);
                        dq_oe     <= wr_en;
                        dq_out    <= write_data[15:0];
                    end
                end

                LOW: begin
                    if (cnt == LAST) begin
                        if (!op_wr) read_data[15:0] <= SRAM_DQ;
                        state     <= HIGH;
                        cnt       <= 3'd0;
                        SRAM_ADDR <= {idx, 1'b1};
                        we_n_q    <= ~op_wr | (LAST == 3'd0);
                        dq_out    <= wdata[31:16];
                    end else begin
                        cnt    <= cnt + 3'd1;
                        we_n_q <= ~op_wr | ((cnt + 3'd1) == LAST);
                    end
                end

                HIGH: begin
                    if (cnt == LAST) begin
                        if (!op_wr) read_data[31:16] <= SRAM_DQ;
                        state  <= DONE;
                        cnt    <= 3'd0;
                        we_n_q <= 1'b1;
                        dq_oe  <= 1'b0;
                    end else begin
                        cnt    <= cnt + 3'd1;
                        we_n_q <= ~op_wr | ((cnt + 3'd1) == LAST);
                    end
                end

                DONE: begin
                    // Requests are ignored here; the requester sees ready and
                    // moves on before the next IDLE sample.
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;
    assign SRAM_WE_N = we_n_q;

    // The SRAM stays selected and output-enabled; direction is resolved by
    // WE_N alone. During reset the chip is deselected.
    assign SRAM_CE_N = ~rst;
    assign SRAM_OE_N = ~rst;
    assign SRAM_UB_N = ~rst;
    assign SRAM_LB_N = ~rst;

endmodule

// File: tb/tb_sram_controller.sv
// -----------------------------------------------------------------------------
// tb_sram_controller
//   Scoreboarded bench for sram_controller. Unit u0 (PHASE_CYCLES=2) runs
//   directed and random traffic against a word-level reference memory; its
//   SRAM is a half-word array. Unit u1 (PHASE_CYCLES=1) runs back-to-back
//   reads against an address-derived data pattern.
// -----------------------------------------------------------------------------
module tb_sram_controller;

    localparam int P0 = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    // ---------------- u0 ----------------
    logic        u0_wr, u0_rd;
    logic [31:0] u0_addr, u0_wdata, u0_rdata;
    logic        u0_ready;
    wire  [15:0] u0_dq;
    logic [17:0] u0_sa;
    logic        u0_ub, u0_lb, u0_ce, u0_oe, u0_we;
    logic        tb_rd_active;

    sram_controller #(.PHASE_CYCLES(P0), .ADDR_BASE(32'd1024)) u0 (
        .clk(clk), .rst(rst), .wr_en(u0_wr), .rd_en(u0_rd),
        .address(u0_addr), .write_data(u0_wdata), .read_data(u0_rdata),
        .ready(u0_ready), .SRAM_DQ(u0_dq), .SRAM_ADDR(u0_sa),
        .SRAM_UB_N(u0_ub), .SRAM_LB_N(u0_lb), .SRAM_CE_N(u0_ce),
        .SRAM_OE_N(u0_oe), .SRAM_WE_N(u0_we)
    );

    logic [15:0] mem [0:262143];
    always @(posedge clk) if (!u0_we) mem[u0_sa] <= u0_dq;
    assign u0_dq = tb_rd_active ? mem[u0_sa] : 16'hzzzz;

    // ---------------- u1 ----------------
    logic        u1_wr, u1_rd;
    logic [31:0] u1_addr, u1_wdata, u1_rdata;
    logic        u1_ready;
    wire  [15:0] u1_dq;
    logic [17:0] u1_sa;
    logic        u1_ub, u1_lb, u1_ce, u1_oe, u1_we;

    sram_controller #(.PHASE_CYCLES(1), .ADDR_BASE(32'd1024)) u1 (
        .clk(clk), .rst(rst), .wr_en(u1_wr), .rd_en(u1_rd),
        .address(u1_addr), .write_data(u1_wdata), .read_data(u1_rdata),
        .ready(u1_ready), .SRAM_DQ(u1_dq), .SRAM_ADDR(u1_sa),
        .SRAM_UB_N(u1_ub), .SRAM_LB_N(u1_lb), .SRAM_CE_N(u1_ce),
        .SRAM_OE_N(u1_oe), .SRAM_WE_N(u1_we)
    );

    function automatic logic [15:0] f1(input logic [17:0] h);
        return h[15:0] ^ {h[17:16], 14'h25C3};
    endfunction
    assign u1_dq = u1_rd ? f1(u1_sa) : 16'hzzzz;

    // ---------------- reference model ----------------
    typedef struct {
        int          lat;
        int          we;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [int];
    logic [31:0] last_rd;

    function automatic int idx_of(input logic [31:0] a);
        logic [31:0] w;
        w = (a - 32'd1024) >> 2;
        return int'(w & 32'h1FFFF);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one u0 request, push its expected completion, wait for DONE.
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        int   i;
        int   n;
        @(posedge clk); #1;
        u0_rd = rd; u0_wr = wr; u0_addr = a; u0_wdata = d;
        i = idx_of(a);
        e.lat = 2 * P0 + 1;
        if (wr) begin
            ref_mem[i] = d;
            e.we   = 2 * (P0 - 1);
            e.data = last_rd;
        end else begin
            e.we   = 0;
            e.data = ref_mem.exists(i) ? ref_mem[i] : 32'h0;
            last_rd = e.data;
            tb_rd_active = 1'b1;
        end
        exp_q.push_back(e);
        n = 0;
        do begin @(negedge clk); n++; end while (!u0_ready && n < 40);
        if (!u0_ready) begin
            vecs++; errs++;
            $display("FAIL timeout: ready stayed %b expected 1", u0_ready);
        end
        @(posedge clk); #1;
        u0_rd = 1'b0; u0_wr = 1'b0; tb_rd_active = 1'b0;
    endtask

    // ---------------- monitor ----------------
    initial begin
        int   lowcnt;
        int   wecnt;
        exp_t e;
        lowcnt = 0; wecnt = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                lowcnt = 0; wecnt = 0;
            end else if (!u0_ready) begin
                lowcnt++;
                if (!u0_we) wecnt++;
            end else if (lowcnt > 0) begin
                if (exp_q.size() == 0) begin
                    vecs++; errs++;
                    $display("FAIL unexpected_done: got done with %0d low cycles expected none", lowcnt);
                end else begin
                    e = exp_q.pop_front();
                    chk("latency", lowcnt, e.lat);
                    chk("we_low_cycles", wecnt, e.we);
                    chk("read_data", u0_rdata, e.data);
                end
                lowcnt = 0; wecnt = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        rst = 1'b0;
        u0_wr = 0; u0_rd = 0; u0_addr = 0; u0_wdata = 0; tb_rd_active = 0;
        u1_wr = 0; u1_rd = 0; u1_addr = 0; u1_wdata = 0;
        last_rd = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_read_data", u0_rdata, 32'h0);
        chk("rst_we_n", u0_we, 1'b1);
        chk("rst_sram_addr", u0_sa, 18'h0);
        chk("rst_ready", u0_ready, 1'b1);
        rst = 1'b1;
        #1;
        chk("ce_n", u0_ce, 1'b0);
        chk("oe_n", u0_oe, 1'b0);

        // Directed: basic write/read, write priority, below-base wrap.
        do_req(1'b0, 1'b1, 32'd1024, 32'h12345678);
        do_req(1'b1, 1'b0, 32'd1024, 32'h0);
        do_req(1'b1, 1'b1, 32'd1028, 32'hAAAA5555);
        chk("mem_h0", {16'h0, mem[0]}, 32'h5678);
        chk("mem_h1", {16'h0, mem[1]}, 32'h1234);
        chk("mem_h2", {16'h0, mem[2]}, 32'h5555);
        chk("mem_h3", {16'h0, mem[3]}, 32'hAAAA);
        do_req(1'b0, 1'b1, 32'd1020, 32'hCAFEF00D);
        chk("mem_h3fffe", {16'h0, mem[18'h3FFFE]}, 32'hF00D);
        chk("mem_h3ffff", {16'h0, mem[18'h3FFFF]}, 32'hCAFE);
        do_req(1'b1, 1'b0, 32'd1020, 32'h0);

        // Reset during the HIGH phase of a write: low half lands, high doesn't.
        @(posedge clk); #1;
        u0_wr = 1'b1; u0_addr = 32'd1024; u0_wdata = 32'hDEADBEEF;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_we_before", u0_we, 1'b0);
        rst = 1'b0; u0_wr = 1'b0;
        #1;
        chk("abort_we_n", u0_we, 1'b1);
        chk("abort_sram_addr", u0_sa, 18'h0);
        chk("abort_read_data", u0_rdata, 32'h0);
        ref_mem[0] = {ref_mem[0][31:16], 16'hBEEF};
        last_rd = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        do_req(1'b1, 1'b0, 32'd1024, 32'h0);

        // Prefill the random window, then random traffic.
        for (int k = -3; k <= 7; k++)
            do_req(1'b0, 1'b1, 32'(1024 + 4 * k), $urandom);
        for (int t = 0; t < 60; t++) begin
            int          op;
            logic [31:0] a;
            op = int'($urandom_range(0, 2));
            a  = 32'(1024 + 4 * (int'($urandom_range(0, 10)) - 3) + int'($urandom_range(0, 3)));
            do_req(op == 0, op != 0, a, $urandom);
        end

        repeat (3) @(posedge clk);
        chk("pending_responses", exp_q.size(), 0);
        foreach (ref_mem[i]) begin
            chk("final_mem_lo", {16'h0, mem[18'(2 * i)]}, {16'h0, ref_mem[i][15:0]});
            chk("final_mem_hi", {16'h0, mem[18'(2 * i + 1)]}, {16'h0, ref_mem[i][31:16]});
        end

        // u1: back-to-back reads with single-cycle phases.
        @(posedge clk); #1;
        for (int j = 0; j < 7; j++) begin
            logic [31:0] a;
            logic [16:0] wi;
            a  = (j == 6) ? 32'd1020 : 32'(1024 + 4 * j + j % 4);
            wi = 17'(idx_of(a));
            u1_rd = 1'b1; u1_addr = a;
            n = 0;
            do begin @(negedge clk); n++; end while (!u1_ready && n < 20);
            chk("p1_ready_low", n - 1, 3);
            chk("p1_read_data", u1_rdata, {f1({wi, 1'b1}), f1({wi, 1'b0})});
            @(posedge clk); #1;
        end
        u1_rd = 1'b0;
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 SHALL have parameter PHASE_CYCLES, default 2, number of clocks each 16-bit half-access is held on the SRAM pins (legal 1..7).
REQ-002 SHALL have parameter ADDR_BASE, default 1024, byte address mapped to SRAM word 0.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 wr_en  input  1  32-bit write request from memory stage.
REQ-006 rd_en  input  1  32-bit read request from memory stage.
REQ-007 address  input  32  byte address of request; bits [1:0] ignored.
REQ-008 write_data  input  32  data for write request.
REQ-009 read_data  output  32  last completed read word.
REQ-010 ready  output  1  high when no access is in progress; low freezes the pipeline.
REQ-011 SRAM_DQ  inout  16  SRAM data bus.
REQ-012 SRAM_ADDR  output  18  SRAM half-word address.
REQ-013 SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N  output  1 each  SRAM strobes, active-low.
REQ-014 SRAM_WE_N  output  1  SRAM write enable, active-low.

Function
REQ-015 SHALL implement FSM states IDLE, LOW, HIGH, DONE.
REQ-016 IDLE: ready = ~(rd_en | wr_en), combinational, so the requesting cycle is frozen.
REQ-017 IDLE with rd_en or wr_en sampled high at edge T SHALL capture address, write_data, and operation type, then enter LOW at T+1.
REQ-018 rd_en and wr_en both high SHALL be treated as a write.
REQ-019 Word index = (address - ADDR_BASE) >> 2, truncated to 17 bits; out-of-range addresses wrap modulo 2^17 with no error.
REQ-020 LOW phase: cycles T+1..T+PHASE_CYCLES, SRAM_ADDR = {index, 1'b0}; HIGH phase: next PHASE_CYCLES cycles, SRAM_ADDR = {index, 1'b1}.
REQ-021 Write: SRAM_DQ driven with write_data[15:0] in LOW and write_data[31:16] in HIGH; SRAM_WE_N = 0 in all phase cycles except the last cycle of each phase, which is 1.
REQ-022 Read: SRAM_WE_N = 1 and SRAM_DQ high-Z; SRAM_DQ sampled into read_data[15:0] on the last LOW cycle and into read_data[31:16] on the last HIGH cycle.
REQ-023 SRAM_DQ SHALL be high-Z whenever not in a write phase.
REQ-024 A phase counter (3 bits) SHALL count 0..PHASE_CYCLES-1 and reset to 0 on each phase entry.
REQ-025 DONE: exactly one cycle at T+2*PHASE_CYCLES+1, ready = 1, read_data valid for reads; rd_en/wr_en SHALL be ignored; next state IDLE.
REQ-026 Total latency: ready low for 2*PHASE_CYCLES+1 cycles (5 at default), counted from the request cycle.
REQ-027 A read SHALL update read_data; a write SHALL leave read_data unchanged; read_data is held between reads.
REQ-028 SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N SHALL be constant 0 outside reset.
REQ-029 Requesters SHALL hold rd_en/wr_en, address, and write_data stable until ready; the controller uses only the captured copies.

Reset
REQ-030 rst low SHALL immediately force state IDLE, counter 0, read_data 0, SRAM_WE_N 1, SRAM_DQ high-Z, SRAM_ADDR 0.
REQ-031 rst asserted mid-access SHALL abort the access without completing the pending half, and SHALL produce no DONE pulse.
REQ-032 After rst releases, the first request SHALL be accepted on the next rising edge with rd_en/wr_en high.

Verification
REQ-033 Write 0x12345678 to 1024 -> SRAM half-address 0 = 0x5678, half-address 1 = 0x1234, WE_N low in cycles 1 and 3 only, ready low 5 cycles.
REQ-034 Read of 1024 after REQ-033 -> read_data = 0x12345678 in the DONE cycle, ready = 1 exactly there.
REQ-035 rd_en and wr_en both high at 1028 with data 0xAAAA5555 -> write occurs at half-addresses 2 and 3, read_data unchanged.
REQ-036 Address 1020 (below base) -> index 0x1FFFF, half-addresses 0x3FFFE and 0x3FFFF used.
REQ-037 rst low during HIGH of a write -> WE_N = 1, DQ = Z within same cycle, no ready pulse from DONE, half-address 1 retains old value.
REQ-038 PHASE_CYCLES = 1 back-to-back reads -> each read has 3 cycles ready-low, with one ready-high DONE cycle between requests.
